// File: rtl/rat_pkg.sv
// Shared encodings for the RAT control unit: FSM states, opcodes, ALU
// operation codes and the decoded control-strobe bundle.
package rat_pkg;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_INTR  = 2'd3
    } state_t;

    // ALU operation codes; these values are also decoded by the ALU.
    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_ADDC = 4'h1;
    localparam logic [3:0] ALU_SUB  = 4'h2;
    localparam logic [3:0] ALU_SUBC = 4'h3;
    localparam logic [3:0] ALU_CMP  = 4'h4;
    localparam logic [3:0] ALU_AND  = 4'h5;
    localparam logic [3:0] ALU_OR   = 4'h6;
    localparam logic [3:0] ALU_EXOR = 4'h7;
    localparam logic [3:0] ALU_TEST = 4'h8;
    localparam logic [3:0] ALU_LSL  = 4'h9;
    localparam logic [3:0] ALU_LSR  = 4'hA;
    localparam logic [3:0] ALU_ROL  = 4'hB;
    localparam logic [3:0] ALU_ROR  = 4'hC;
    localparam logic [3:0] ALU_ASR  = 4'hD;
    localparam logic [3:0] ALU_MOV  = 4'hE;

    localparam logic [1:0] PCM_BRANCH = 2'd0;
    localparam logic [1:0] PCM_RETURN = 2'd1;
    localparam logic [1:0] PCM_VECTOR = 2'd2;

    // Full 7-bit opcodes {IR[17:13], IR[1:0]}
    localparam logic [6:0] OP_AND   = 7'b0000000;
    localparam logic [6:0] OP_OR    = 7'b0000001;
    localparam logic [6:0] OP_EXOR  = 7'b0000010;
    localparam logic [6:0] OP_TEST  = 7'b0000011;
    localparam logic [6:0] OP_ADD   = 7'b0000100;
    localparam logic [6:0] OP_ADDC  = 7'b0000101;
    localparam logic [6:0] OP_SUB   = 7'b0000110;
    localparam logic [6:0] OP_SUBC  = 7'b0000111;
    localparam logic [6:0] OP_CMP   = 7'b0001000;
    localparam logic [6:0] OP_MOV   = 7'b0001001;
    localparam logic [6:0] OP_BRN   = 7'b0010000;
    localparam logic [6:0] OP_BREQ  = 7'b0010010;
    localparam logic [6:0] OP_BRNE  = 7'b0010011;
    localparam logic [6:0] OP_BRCS  = 7'b0010100;
    localparam logic [6:0] OP_BRCC  = 7'b0010101;
    localparam logic [6:0] OP_LSL   = 7'b0100000;
    localparam logic [6:0] OP_LSR   = 7'b0100001;
    localparam logic [6:0] OP_ROL   = 7'b0100010;
    localparam logic [6:0] OP_ROR   = 7'b0100011;
    localparam logic [6:0] OP_ASR   = 7'b0100100;
    localparam logic [6:0] OP_CLC   = 7'b0110000;
    localparam logic [6:0] OP_SEC   = 7'b0110001;
    localparam logic [6:0] OP_SEI   = 7'b0110100;
    localparam logic [6:0] OP_CLI   = 7'b0110101;
    localparam logic [6:0] OP_RETIE = 7'b0110111;

    // Immediate forms are identified by the upper five bits only.
    localparam logic [4:0] OPI_AND  = 5'b10000;
    localparam logic [4:0] OPI_OR   = 5'b10001;
    localparam logic [4:0] OPI_EXOR = 5'b10010;
    localparam logic [4:0] OPI_TEST = 5'b10011;
    localparam logic [4:0] OPI_ADD  = 5'b10100;
    localparam logic [4:0] OPI_ADDC = 5'b10101;
    localparam logic [4:0] OPI_SUB  = 5'b10110;
    localparam logic [4:0] OPI_SUBC = 5'b10111;
    localparam logic [4:0] OPI_CMP  = 5'b11000;
    localparam logic [4:0] OPI_MOV  = 5'b11011;

    typedef struct packed {
        logic       pc_inc;
        logic       pc_ld;
        logic [1:0] pc_mux_sel;
        logic       pc_save;
        logic       ir_ld;
        logic       rf_wr;
        logic       alu_opy_sel;
        logic [3:0] alu_sel;
        logic       flg_c_ld;
        logic       flg_z_ld;
        logic       flg_c_set;
        logic       flg_c_clr;
        logic       flg_shad_ld;
        logic       flg_ld_sel;
    } ctrl_t;

    // Strobes shared by every ALU instruction, derived from its operation class.
    function automatic ctrl_t alu_ctrl(input logic [3:0] sel, input logic imm);
        ctrl_t c;
        c             = '0;
        c.alu_sel     = sel;
        c.alu_opy_sel = imm;
        c.rf_wr       = (sel != ALU_CMP) && (sel != ALU_TEST);
        case (sel)
            ALU_AND, ALU_OR, ALU_EXOR, ALU_TEST: begin
                c.flg_z_ld  = 1'b1;
                c.flg_c_clr = 1'b1;
            end
            ALU_MOV: ;
            default: begin
                c.flg_c_ld = 1'b1;
                c.flg_z_ld = 1'b1;
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/rat_decoder.sv
// Combinational EXEC-cycle decode: opcode and current flags to datapath
// strobes, plus interrupt-enable set/clear requests.
module rat_decoder
    import rat_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic       c_flag,
    input  logic       z_flag,
    output ctrl_t      ctrl,
    output logic       ie_set,
    output logic       ie_clr
);

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        ctrl   = '0;
        ie_set = 1'b0;
        ie_clr = 1'b0;
        if (opcode[6]) begin
            // Immediate forms: the two low bits belong to the immediate field.
            case (opcode[6:2])
                OPI_AND:  ctrl = alu_ctrl(ALU_AND,  1'b1);
                OPI_OR:   ctrl = alu_ctrl(ALU_OR,   1'b1);
                OPI_EXOR: ctrl = alu_ctrl(ALU_EXOR, 1'b1);
                OPI_TEST: ctrl = alu_ctrl(ALU_TEST, 1'b1);
                OPI_ADD:  ctrl = alu_ctrl(ALU_ADD,  1'b1);
                OPI_ADDC: ctrl = alu_ctrl(ALU_ADDC, 1'b1);
                OPI_SUB:  ctrl = alu_ctrl(ALU_SUB,  1'b1);
                OPI_SUBC: ctrl = alu_ctrl(ALU_SUBC, 1'b1);
                OPI_CMP:  ctrl = alu_ctrl(ALU_CMP,  1'b1);
                OPI_MOV:  ctrl = alu_ctrl(ALU_MOV,  1'b1);
                default:  ;
            endcase
        end else begin
            case (opcode)
                OP_AND:   ctrl = alu_ctrl(ALU_AND,  1'b0);
                OP_OR:    ctrl = alu_ctrl(ALU_OR,   1'b0);
                OP_EXOR:  ctrl = alu_ctrl(ALU_EXOR, 1'b0);
                OP_TEST:  ctrl = alu_ctrl(ALU_TEST, 1'b0);
                OP_ADD:   ctrl = alu_ctrl(ALU_ADD,  1'b0);
                OP_ADDC:  ctrl = alu_ctrl(ALU_ADDC, 1'b0);
                OP_SUB:   ctrl = alu_ctrl(ALU_SUB,  1'b0);
                OP_SUBC:  ctrl = alu_ctrl(ALU_SUBC, 1'b0);
                OP_CMP:   ctrl = alu_ctrl(ALU_CMP,  1'b0);
                OP_MOV:   ctrl = alu_ctrl(ALU_MOV,  1'b0);
                OP_LSL:   ctrl = alu_ctrl(ALU_LSL,  1'b0);
                OP_LSR:   ctrl = alu_ctrl(ALU_LSR,  1'b0);
                OP_ROL:   ctrl = alu_ctrl(ALU_ROL,  1'b0);
                OP_ROR:   ctrl = alu_ctrl(ALU_ROR,  1'b0);
                OP_ASR:   ctrl = alu_ctrl(ALU_ASR,  1'b0);
                OP_BRN:   ctrl.pc_ld = 1'b1;
                OP_BREQ:  ctrl.pc_ld = z_flag;
                OP_BRNE:  ctrl.pc_ld = !z_flag;
                OP_BRCS:  ctrl.pc_ld = c_flag;
                OP_BRCC:  ctrl.pc_ld = !c_flag;
                OP_CLC:   ctrl.flg_c_clr = 1'b1;
                OP_SEC:   ctrl.flg_c_set = 1'b1;
                OP_SEI:   ie_set = 1'b1;
                OP_CLI:   ie_clr = 1'b1;
                OP_RETIE: begin
                    ctrl.pc_ld      = 1'b1;
                    ctrl.pc_mux_sel = PCM_RETURN;
                    ctrl.flg_c_ld   = 1'b1;
                    ctrl.flg_z_ld   = 1'b1;
                    ctrl.flg_ld_sel = 1'b1;
                    ie_set          = 1'b1;
                end
                default:  ;
            endcase
        end
    end

endmodule

// File: rtl/rat_control_unit.sv
// RAT CPU control unit: INIT/FETCH/EXEC/INTR sequencer, interrupt-enable
// register and output gating around the opcode decoder.
module rat_control_unit
    import rat_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       c_flag,
    input  logic       z_flag,
    input  logic       int_req,
    output logic       pc_inc,
    output logic       pc_ld,
    output logic [1:0] pc_mux_sel,
    output logic       pc_save,
    output logic       ir_ld,
    output logic       rf_wr,
    output logic       alu_opy_sel,
    output logic [3:0] alu_sel,
    output logic       flg_c_ld,
    output logic       flg_z_ld,
    output logic       flg_c_set,
    output logic       flg_c_clr,
    output logic       flg_shad_ld,
    output logic       flg_ld_sel,
    output logic       ie,
    output logic       rst
);

    state_t state;
    state_t state_nxt;
    ctrl_t  dec;
    ctrl_t  strb;
    logic   dec_ie_set;
    logic   dec_ie_clr;

    rat_decoder u_decoder (
        .opcode (opcode),
        .c_flag (c_flag),
        .z_flag (z_flag),
        .ctrl   (dec),
        .ie_set (dec_ie_set),
        .ie_clr (dec_ie_clr)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state <= ST_INIT;
        else       state <= state_nxt;
    end

    // The interrupt decision sees IE before this instruction's own update.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_INIT:  state_nxt = ST_FETCH;
            ST_FETCH: state_nxt = ST_EXEC;
            ST_EXEC:  state_nxt = (int_req && ie) ? ST_INTR : ST_FETCH;
            ST_INTR:  state_nxt = ST_FETCH;
            default:  state_nxt = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)                            ie <= 1'b0;
        else if (state == ST_INTR)            ie <= 1'b0;
        else if (state == ST_EXEC && dec_ie_set) ie <= 1'b1;
        else if (state == ST_EXEC && dec_ie_clr) ie <= 1'b0;
    end

    // Reset overrides the state so a mid-instruction reset writes nothing.
    always_comb begin
        strb = '0;
        rst  = 1'b0;
        if (reset) begin
            rst = 1'b1;
        end else begin
            case (state)
                ST_INIT:  rst = 1'b1;
                ST_FETCH: begin
                    strb.ir_ld  = 1'b1;
                    strb.pc_inc = 1'b1;
                end
                ST_EXEC:  strb = dec;
                ST_INTR:  begin
                    strb.pc_save     = 1'b1;
                    strb.pc_ld       = 1'b1;
                    strb.pc_mux_sel  = PCM_VECTOR;
                    strb.flg_shad_ld = 1'b1;
                end
                default:  ;
            endcase
        end
    end

    assign pc_inc      = strb.pc_inc;
    assign pc_ld       = strb.pc_ld;
    assign pc_mux_sel  = strb.pc_mux_sel;
    assign pc_save     = strb.pc_save;
    assign ir_ld       = strb.ir_ld;
    assign rf_wr       = strb.rf_wr;
    assign alu_opy_sel = strb.alu_opy_sel;
    assign alu_sel     = strb.alu_sel;
    assign flg_c_ld    = strb.flg_c_ld;
    assign flg_z_ld    = strb.flg_z_ld;
    assign flg_c_set   = strb.flg_c_set;
    assign flg_c_clr   = strb.flg_c_clr;
    assign flg_shad_ld = strb.flg_shad_ld;
    assign flg_ld_sel  = strb.flg_ld_sel;

endmodule

// File: tb/tb_rat_control_unit.sv
// Directed bench for rat_control_unit: an instruction-level reference model
// is compared every cycle, plus hand-computed literal expectations.
module tb_rat_control_unit;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] opcode = 7'd0;
    logic       c_flag = 1'b0;
    logic       z_flag = 1'b0;
    logic       int_req = 1'b0;
    logic       pc_inc, pc_ld, pc_save, ir_ld, rf_wr, alu_opy_sel;
    logic [1:0] pc_mux_sel;
    logic [3:0] alu_sel;
    logic       flg_c_ld, flg_z_ld, flg_c_set, flg_c_clr, flg_shad_ld, flg_ld_sel;
    logic       ie, rst;

    always #5 clk = ~clk;

    rat_control_unit dut (
        .clk         (clk),
        .reset       (reset),
        .opcode      (opcode),
        .c_flag      (c_flag),
        .z_flag      (z_flag),
        .int_req     (int_req),
        .pc_inc      (pc_inc),
        .pc_ld       (pc_ld),
        .pc_mux_sel  (pc_mux_sel),
        .pc_save     (pc_save),
        .ir_ld       (ir_ld),
        .rf_wr       (rf_wr),
        .alu_opy_sel (alu_opy_sel),
        .alu_sel     (alu_sel),
        .flg_c_ld    (flg_c_ld),
        .flg_z_ld    (flg_z_ld),
        .flg_c_set   (flg_c_set),
        .flg_c_clr   (flg_c_clr),
        .flg_shad_ld (flg_shad_ld),
        .flg_ld_sel  (flg_ld_sel),
        .ie          (ie),
        .rst         (rst)
    );

    localparam logic [6:0] ADD_R  = 7'b0000100;
    localparam logic [6:0] TEST_R = 7'b0000011;
    localparam logic [6:0] EXOR_R = 7'b0000010;
    localparam logic [6:0] LD_R   = 7'b0001010;
    localparam logic [6:0] CMP_I  = 7'b1100011;
    localparam logic [6:0] AND_I  = 7'b1000010;
    localparam logic [6:0] SUBC_I = 7'b1011101;
    localparam logic [6:0] MOV_I  = 7'b1101101;
    localparam logic [6:0] UNDEF  = 7'b1111111;
    localparam logic [6:0] BRN    = 7'b0010000;
    localparam logic [6:0] BREQ   = 7'b0010010;
    localparam logic [6:0] BRNE   = 7'b0010011;
    localparam logic [6:0] BRCS   = 7'b0010100;
    localparam logic [6:0] BRCC   = 7'b0010101;
    localparam logic [6:0] LSL    = 7'b0100000;
    localparam logic [6:0] ROR    = 7'b0100011;
    localparam logic [6:0] ASR    = 7'b0100100;
    localparam logic [6:0] CLC    = 7'b0110000;
    localparam logic [6:0] SEC    = 7'b0110001;
    localparam logic [6:0] SEI    = 7'b0110100;
    localparam logic [6:0] CLI    = 7'b0110101;
    localparam logic [6:0] RETIE  = 7'b0110111;

    typedef enum {PH_INIT, PH_FETCH, PH_EXEC, PH_INTR} phase_t;
    typedef enum {K_NOP, K_ALU, K_BRN, K_BREQ, K_BRNE, K_BRCS, K_BRCC,
                  K_CLC, K_SEC, K_SEI, K_CLI, K_RETIE} kind_t;

    typedef struct packed {
        logic       rst;
        logic       pc_inc;
        logic       pc_ld;
        logic [1:0] pc_mux_sel;
        logic       pc_save;
        logic       ir_ld;
        logic       rf_wr;
        logic       alu_opy_sel;
        logic [3:0] alu_sel;
        logic       flg_c_ld;
        logic       flg_z_ld;
        logic       flg_c_set;
        logic       flg_c_clr;
        logic       flg_shad_ld;
        logic       flg_ld_sel;
        logic       ie;
    } outs_t;

    // ALU code by instruction number within the logic/arith group
    // (AND OR EXOR TEST ADD ADDC SUB SUBC CMP MOV).
    logic [3:0] group_alu [0:9] = '{4'h5, 4'h6, 4'h7, 4'h8, 4'h0,
                                   4'h1, 4'h2, 4'h3, 4'h4, 4'hE};

    int     vectors = 0;
    int     miscompares = 0;
    phase_t m_phase = PH_INIT;
    logic   m_ie = 1'b0;
    bit     chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic void classify(input logic [6:0] op, output kind_t k,
                                     output logic [3:0] alu, output logic imm);
        k   = K_NOP;
        alu = 4'h0;
        imm = 1'b0;
        if (op <= 7'd9) begin
            k = K_ALU; alu = group_alu[int'(op)];
        end else if (op[6:5] == 2'b10) begin
            k = K_ALU; alu = group_alu[int'(op[4:2])]; imm = 1'b1;
        end else if (op[6:2] == 5'b11000) begin
            k = K_ALU; alu = 4'h4; imm = 1'b1;
        end else if (op[6:2] == 5'b11011) begin
            k = K_ALU; alu = 4'hE; imm = 1'b1;
        end else if (op >= 7'h20 && op <= 7'h24) begin
            k = K_ALU; alu = 4'(9 + int'(op[2:0]));
        end else begin
            case (op)
                7'h10:   k = K_BRN;
                7'h12:   k = K_BREQ;
                7'h13:   k = K_BRNE;
                7'h14:   k = K_BRCS;
                7'h15:   k = K_BRCC;
                7'h30:   k = K_CLC;
                7'h31:   k = K_SEC;
                7'h34:   k = K_SEI;
                7'h35:   k = K_CLI;
                7'h37:   k = K_RETIE;
                default: k = K_NOP;
            endcase
        end
    endfunction

    function automatic outs_t model_out(input phase_t ph, input logic rs, input logic [6:0] op,
                                        input logic c, input logic z, input logic m_ie_now);
        outs_t o;
        kind_t k;
        logic [3:0] a;
        logic im;
        o = '0;
        o.ie = m_ie_now;
        if (rs) begin
            o.rst = 1'b1;
            return o;
        end
        case (ph)
            PH_INIT:  o.rst = 1'b1;
            PH_FETCH: begin o.ir_ld = 1'b1; o.pc_inc = 1'b1; end
            PH_INTR:  begin
                o.pc_save = 1'b1; o.pc_ld = 1'b1; o.pc_mux_sel = 2'd2; o.flg_shad_ld = 1'b1;
            end
            PH_EXEC:  begin
                classify(op, k, a, im);
                case (k)
                    K_ALU: begin
                        o.alu_sel = a;
                        o.alu_opy_sel = im;
                        o.rf_wr = !(a == 4'h4 || a == 4'h8);
                        if (a >= 4'h5 && a <= 4'h8) begin
                            o.flg_z_ld = 1'b1; o.flg_c_clr = 1'b1;
                        end else if (a != 4'hE) begin
                            o.flg_c_ld = 1'b1; o.flg_z_ld = 1'b1;
                        end
                    end
                    K_BRN:   o.pc_ld = 1'b1;
                    K_BREQ:  o.pc_ld = z;
                    K_BRNE:  o.pc_ld = !z;
                    K_BRCS:  o.pc_ld = c;
                    K_BRCC:  o.pc_ld = !c;
                    K_CLC:   o.flg_c_clr = 1'b1;
                    K_SEC:   o.flg_c_set = 1'b1;
                    K_RETIE: begin
                        o.pc_ld = 1'b1; o.pc_mux_sel = 2'd1;
                        o.flg_c_ld = 1'b1; o.flg_z_ld = 1'b1; o.flg_ld_sel = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
        return o;
    endfunction

    // Reference sequencer: advances one phase per clock from the instruction rules.
    always @(posedge clk) begin
        kind_t k;
        logic [3:0] a;
        logic im;
        classify(opcode, k, a, im);
        if (reset) begin
            m_phase = PH_INIT;
            m_ie    = 1'b0;
        end else begin
            case (m_phase)
                PH_INIT:  m_phase = PH_FETCH;
                PH_FETCH: m_phase = PH_EXEC;
                PH_EXEC:  begin
                    m_phase = (int_req && m_ie) ? PH_INTR : PH_FETCH;
                    if (k == K_SEI || k == K_RETIE) m_ie = 1'b1;
                    if (k == K_CLI) m_ie = 1'b0;
                end
                default: begin
                    m_phase = PH_FETCH;
                    m_ie    = 1'b0;
                end
            endcase
        end
        chk_en = 1'b1;
    end

    always @(negedge clk) begin
        outs_t act_o;
        outs_t exp_o;
        if (chk_en) begin
            act_o = {rst, pc_inc, pc_ld, pc_mux_sel, pc_save, ir_ld, rf_wr, alu_opy_sel,
                     alu_sel, flg_c_ld, flg_z_ld, flg_c_set, flg_c_clr, flg_shad_ld,
                     flg_ld_sel, ie};
            exp_o = model_out(m_phase, reset, opcode, c_flag, z_flag, m_ie);
            check($sformatf("cycle op=%b ph=%s", opcode, m_phase.name()), 32'(act_o), 32'(exp_o));
        end
    end

    task automatic step(input logic rs, input logic [6:0] op, input logic c,
                        input logic z, input logic irq);
        @(posedge clk);
        #1;
        reset = rs; opcode = op; c_flag = c; z_flag = z; int_req = irq;
        @(negedge clk);
        #1;
    endtask

    // One uninterrupted fetch/execute pair; returns inside the EXEC cycle.
    task automatic instr(input logic [6:0] op, input logic c, input logic z, input logic irq);
        step(1'b0, op, c, z, 1'b0);
        step(1'b0, op, c, z, irq);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) step(1'b1, ADD_R, 1'b0, 1'b0, 1'b0);
        check("reset rst", 32'(rst), 32'd1);
        check("reset rf_wr", 32'(rf_wr), 32'd0);

        step(1'b0, ADD_R, 1'b0, 1'b0, 1'b0);
        check("init rst", 32'(rst), 32'd1);
        check("init ir_ld", 32'(ir_ld), 32'd0);
        step(1'b0, ADD_R, 1'b0, 1'b0, 1'b0);
        check("fetch ir_ld", 32'(ir_ld), 32'd1);
        check("fetch pc_inc", 32'(pc_inc), 32'd1);
        check("fetch ie", 32'(ie), 32'd0);
        check("fetch rst", 32'(rst), 32'd0);
        step(1'b0, ADD_R, 1'b0, 1'b0, 1'b0);
        check("add alu_sel", 32'(alu_sel), 32'h0);
        check("add opy_sel", 32'(alu_opy_sel), 32'd0);
        check("add rf_wr", 32'(rf_wr), 32'd1);
        check("add flg_c/z_ld", 32'({flg_c_ld, flg_z_ld}), 32'b11);

        instr(CMP_I, 1'b0, 1'b0, 1'b0);
        check("cmp_i alu_sel", 32'(alu_sel), 32'h4);
        check("cmp_i opy_sel", 32'(alu_opy_sel), 32'd1);
        check("cmp_i rf_wr", 32'(rf_wr), 32'd0);
        check("cmp_i flg_c/z_ld", 32'({flg_c_ld, flg_z_ld}), 32'b11);

        instr(BREQ, 1'b0, 1'b1, 1'b0);
        check("breq z=1 pc_ld", 32'(pc_ld), 32'd1);
        check("breq z=1 mux", 32'(pc_mux_sel), 32'd0);
        instr(BREQ, 1'b0, 1'b0, 1'b0);
        check("breq z=0 pc_ld", 32'(pc_ld), 32'd0);
        instr(BRNE, 1'b0, 1'b0, 1'b0);
        instr(BRCS, 1'b1, 1'b0, 1'b0);
        instr(BRCC, 1'b1, 1'b0, 1'b0);
        check("brcc c=1 pc_ld", 32'(pc_ld), 32'd0);
        instr(BRN, 1'b0, 1'b1, 1'b0);

        instr(AND_I, 1'b0, 1'b0, 1'b0);
        check("and_i flags", 32'({flg_c_ld, flg_z_ld, flg_c_clr}), 32'b011);
        instr(TEST_R, 1'b0, 1'b0, 1'b0);
        check("test rf_wr", 32'(rf_wr), 32'd0);
        instr(MOV_I, 1'b0, 1'b0, 1'b0);
        check("mov_i alu_sel", 32'(alu_sel), 32'hE);
        check("mov_i flags", 32'({flg_c_ld, flg_z_ld, flg_c_clr, flg_c_set}), 32'd0);
        instr(EXOR_R, 1'b0, 1'b0, 1'b0);
        instr(SUBC_I, 1'b0, 1'b0, 1'b0);
        instr(LSL, 1'b0, 1'b0, 1'b0);
        instr(ROR, 1'b0, 1'b0, 1'b0);
        check("ror alu_sel", 32'(alu_sel), 32'hC);
        instr(ASR, 1'b0, 1'b0, 1'b0);
        instr(CLC, 1'b0, 1'b0, 1'b0);
        check("clc c_clr", 32'(flg_c_clr), 32'd1);
        instr(SEC, 1'b0, 1'b0, 1'b0);
        check("sec c_set", 32'(flg_c_set), 32'd1);
        instr(LD_R, 1'b0, 1'b0, 1'b0);
        instr(UNDEF, 1'b1, 1'b1, 1'b0);
        check("undef rf_wr", 32'(rf_wr), 32'd0);

        // IE is still clear, so a pending request is ignored.
        instr(ADD_R, 1'b0, 1'b0, 1'b1);
        step(1'b0, SEI, 1'b0, 1'b0, 1'b0);
        check("irq masked -> fetch", 32'(ir_ld), 32'd1);
        step(1'b0, SEI, 1'b0, 1'b0, 1'b1);
        step(1'b0, ADD_R, 1'b0, 1'b0, 1'b0);
        check("sei no intr", 32'(ir_ld), 32'd1);
        check("sei ie", 32'(ie), 32'd1);
        step(1'b0, ADD_R, 1'b0, 1'b0, 1'b1);
        step(1'b0, ADD_R, 1'b0, 1'b0, 1'b0);
        check("intr mux", 32'(pc_mux_sel), 32'd2);
        check("intr save/shad/ld", 32'({pc_save, flg_shad_ld, pc_ld}), 32'b111);
        step(1'b0, RETIE, 1'b0, 1'b0, 1'b0);
        check("after intr ie", 32'(ie), 32'd0);
        step(1'b0, RETIE, 1'b0, 1'b0, 1'b0);
        check("retie mux", 32'(pc_mux_sel), 32'd1);
        check("retie ld_sel", 32'(flg_ld_sel), 32'd1);
        step(1'b0, CLI, 1'b0, 1'b0, 1'b0);
        check("retie ie", 32'(ie), 32'd1);
        step(1'b0, CLI, 1'b0, 1'b0, 1'b1);
        step(1'b0, RETIE, 1'b0, 1'b0, 1'b0);
        check("cli still intr", 32'(pc_save), 32'd1);

        // RETIE with the request still pending: next instruction is interrupted.
        step(1'b0, RETIE, 1'b0, 1'b0, 1'b0);
        step(1'b0, RETIE, 1'b0, 1'b0, 1'b1);
        step(1'b0, ADD_R, 1'b0, 1'b0, 1'b1);
        check("retie irq no intr", 32'(ir_ld), 32'd1);
        step(1'b0, ADD_R, 1'b0, 1'b0, 1'b1);
        step(1'b0, SEI, 1'b0, 1'b0, 1'b0);
        check("re-enter intr", 32'(pc_save), 32'd1);

        // Reset landing in the middle of an EXEC cycle.
        instr(SEI, 1'b0, 1'b0, 1'b0);
        step(1'b0, ADD_R, 1'b0, 1'b0, 1'b0);
        check("pre-reset ie", 32'(ie), 32'd1);
        step(1'b1, ADD_R, 1'b0, 1'b0, 1'b0);
        check("reset in exec rf_wr", 32'(rf_wr), 32'd0);
        check("reset in exec rst", 32'(rst), 32'd1);
        step(1'b0, ADD_R, 1'b0, 1'b0, 1'b0);
        check("post-reset init rst", 32'(rst), 32'd1);
        check("post-reset ie", 32'(ie), 32'd0);
        step(1'b0, ADD_R, 1'b0, 1'b0, 1'b0);
        check("post-reset fetch", 32'(ir_ld), 32'd1);

        @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rat_control_unit.md
RAT_CONTROL_UNIT -- requirements
Module: rat_control_unit

Interface
REQ-001 Parameters SHALL be none; all encodings are fixed constants.
REQ-002 CLK  in  1  sole clock; all state changes on rising edge.
REQ-003 RESET  in  1  synchronous, active-high reset.
REQ-004 OPCODE  in  7  instruction bits {IR[17:13],IR[1:0]}.
REQ-005 C_FLAG, Z_FLAG  in  1 each  current flag-register outputs.
REQ-006 INT  in  1  level-sensitive interrupt request.
REQ-007 PC_INC, PC_LD  out  1 each  program-counter increment/load strobes.
REQ-008 PC_MUX_SEL  out  2  load source: 0 branch immediate, 1 saved PC, 2 vector 0x3FF.
REQ-009 PC_SAVE  out  1  load external return-PC register.
REQ-010 IR_LD  out  1  instruction-register load.
REQ-011 RF_WR  out  1  register-file write of ALU RESULT.
REQ-012 ALU_OPY_SEL  out  1  ALU B source: 0 register, 1 immediate.
REQ-013 ALU_SEL  out  4  ALU operation code.
REQ-014 FLG_C_LD, FLG_Z_LD, FLG_C_SET, FLG_C_CLR  out  1 each  flag-register controls.
REQ-015 FLG_SHAD_LD, FLG_LD_SEL  out  1 each  shadow-flag save; flag source select (0 ALU, 1 shadow).
REQ-016 IE  out  1  interrupt-enable register value.
REQ-017 RST  out  1  datapath reset.

Function
REQ-018 FSM states SHALL be INIT, FETCH, EXEC, INTR; transitions INIT->FETCH, FETCH->EXEC, EXEC->INTR if INT&IE else FETCH, INTR->FETCH.
REQ-019 Every strobe output SHALL default to 0 in any state/opcode not listed below.
REQ-020 INIT: RST=1, all other strobes 0.
REQ-021 FETCH: IR_LD=1, PC_INC=1.
REQ-022 EXEC outputs SHALL decode combinationally from OPCODE, C_FLAG, Z_FLAG; non-interrupted instruction takes exactly 2 cycles.
REQ-023 ALU_SEL: ADD 0, ADDC 1, SUB 2, SUBC 3, CMP 4, AND 5, OR 6, EXOR 7, TEST 8, LSL 9, LSR A, ROL B, ROR C, ASR D, MOV E; 0xF never driven.
REQ-024 Reg-reg forms (opcodes 00000xx-0001001) SHALL drive ALU_OPY_SEL=0; immediate forms (10xxxxx, 11000xx, 11011xx, low 2 bits don't-care) ALU_OPY_SEL=1.
REQ-025 RF_WR=1 for all ALU ops except CMP and TEST.
REQ-026 ADD/ADDC/SUB/SUBC/CMP and LSL/LSR/ROL/ROR/ASR: FLG_C_LD=FLG_Z_LD=1.
REQ-027 AND/OR/EXOR/TEST: FLG_Z_LD=1, FLG_C_CLR=1; MOV: no flag strobes.
REQ-028 Branches: BRN always, BREQ if Z_FLAG, BRNE if !Z_FLAG, BRCS if C_FLAG, BRCC if !C_FLAG; taken -> PC_LD=1, PC_MUX_SEL=0; not taken -> no strobes.
REQ-029 CLC -> FLG_C_CLR=1; SEC -> FLG_C_SET=1; SEI sets IE, CLI clears IE at end of EXEC.
REQ-030 RETIE: PC_LD=1, PC_MUX_SEL=1, FLG_C_LD=FLG_Z_LD=1, FLG_LD_SEL=1, IE set at end of EXEC.
REQ-031 Undefined opcodes SHALL execute as no-op (EXEC, all strobes 0).
REQ-032 Interrupt decision SHALL use IE before the current instruction's update: SEI with INT=1 not taken; CLI with INT=1 taken.
REQ-033 INTR: PC_SAVE=1, PC_LD=1, PC_MUX_SEL=2, FLG_SHAD_LD=1, IE cleared; single cycle.
REQ-034 INT still high after RETIE SHALL re-enter INTR after the next EXEC.

Reset
REQ-035 RESET=1 SHALL gate all strobes to 0 combinationally, drive RST=1, load INIT and clear IE at the edge, including mid-EXEC/INTR.
REQ-036 First FETCH SHALL occur in the second cycle after RESET deasserts.

Structure
REQ-037 Package rat_pkg SHALL hold the state enum, all opcode constants, and ALU_SEL constants shared with the ALU.
REQ-038 Sub-module rat_decoder (combinational opcode-to-strobe decode) SHALL be instantiated; FSM and IE stay in rat_control_unit.

Verification
REQ-039 RESET 3 cycles, release -> RST=1 through INIT, then IR_LD=PC_INC=1 in FETCH, IE=0.
REQ-040 OPCODE=0000100 (ADD reg) in EXEC -> ALU_SEL=0, ALU_OPY_SEL=0, RF_WR=1, FLG_C_LD=FLG_Z_LD=1.
REQ-041 OPCODE=11000xx (CMP imm) -> ALU_SEL=4, ALU_OPY_SEL=1, RF_WR=0, flags loaded.
REQ-042 BREQ with Z_FLAG=1 -> PC_LD=1, PC_MUX_SEL=0; with Z_FLAG=0 -> PC_LD=0.
REQ-043 SEI, then ADD with INT=1 -> INTR next cycle: PC_MUX_SEL=2, PC_SAVE=1, FLG_SHAD_LD=1, IE->0; RETIE -> FLG_LD_SEL=1, IE->1.
REQ-044 RESET asserted in EXEC of ADD -> RF_WR=0 that cycle, state INIT next.
